rr_grant_arbiter: RTL

- Round-robin arbiter that consumes a raw request vector and issues one registered grant, held until acknowledged.
- Sits directly downstream of the request-collection logic and upstream of shared-resource muxes (bus, memory port, MSHR).
- Internally uses two LSB-priority priority_encoder instances, one masked and one unmasked, to pick the next requester at or after a rotating pointer.
- Provides fair, starvation-free access for WIDTH requesters.

---
 rtl/rr_grant_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with a registered grant that is held until acknowledged
// Ports: clock, reset (async active-low), request[WIDTH], grant_ack, lock (only with RR_GRANT_ARBITER_LOCK_EN),
//        grant[WIDTH] one-hot, grant_index[IDX_W], grant_valid.
// Optional macro RR_GRANT_ARBITER_LOCK_EN: an ack with lock=1 keeps the current grant for multi-beat bursts.
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (in[i]) idx = IDX_W'(i);
  end
  assign valid = |in;
endmodule

module rr_grant_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] request,
  input  logic             grant_ack,
`ifdef RR_GRANT_ARBITER_LOCK_EN
  input  logic             lock,
`endif
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             grant_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, inc, arb_ptr, m_idx, u_idx, win, gi_n;
  logic [WIDTH-1:0] e, masked, grant_n;
  logic m_v, u_v, lk, held, gv_n;
`ifdef RR_GRANT_ARBITER_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif
  assign inc = grant_index == IDX_W'(WIDTH - 1) ? '0 : grant_index + 1'b1;
  // on an accept, re-arbitration already uses the advanced pointer and excludes the current winner
  assign arb_ptr = state == GRANT ? inc : ptr;
  assign e = state == GRANT ? request & ~grant : request;
  assign held = |(request & grant);
  always_comb begin
    masked = '0;
    for (int i = 0; i < WIDTH; i++) masked[i] = e[i] && (i >= int'(arb_ptr));
  end
  priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_masked (.in(masked), .idx(m_idx), .valid(m_v));
  priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_plain (.in(e), .idx(u_idx), .valid(u_v));
  assign win = m_v ? m_idx : u_idx;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = grant;
    gi_n = grant_index;
    gv_n = grant_valid;
    if (state == IDLE || (grant_ack && !lk)) begin
      if (state == GRANT) ptr_n = inc;
      state_n = u_v ? GRANT : IDLE;
      grant_n = u_v ? WIDTH'(1) << win : '0;
      gi_n = u_v ? win : '0;
      gv_n = u_v;
    end else if (!held) begin
      state_n = IDLE;
      grant_n = '0;
      gi_n = '0;
      gv_n = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant <= grant_n;
      grant_index <= gi_n;
      grant_valid <= gv_n;
    end
  end
endmodule
